// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM state encoding and the default iteration count.
package muldiv_pkg;

  localparam int ITER_DEFAULT = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_MUL  = 2'd1;
  localparam state_t S_DIV  = 2'd2;
  localparam state_t S_FIN  = 2'd3;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Sign handling for the multiply/divide unit: operand magnitudes going in,
// conditional two's-complement of the 64-bit HI:LO result coming out.
module muldiv_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              is_signed,
  output logic [XLEN-1:0]   a_mag,
  output logic [XLEN-1:0]   b_mag,
  output logic              a_neg,
  output logic              b_neg,
  input  logic [2*XLEN-1:0] res_in,
  input  logic              is_mul,
  input  logic              neg_res,
  input  logic              neg_rem,
  output logic [2*XLEN-1:0] res_out
);

  always_comb begin
    // NOTE: every output is assigned before any branch, so no latch can be inferred.
    a_neg   = is_signed & a[XLEN-1];
    b_neg   = is_signed & b[XLEN-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    res_out = res_in;
    if (is_mul) begin
      if (neg_res) res_out = -res_in;
    end else begin
      // Remainder follows the dividend's sign; quotient follows sign(a)^sign(b).
      if (neg_rem) res_out[2*XLEN-1:XLEN] = -res_in[2*XLEN-1:XLEN];
      if (neg_res) res_out[XLEN-1:0]      = -res_in[XLEN-1:0];
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Optional macro MULDIV_EARLY_OUT_EN: multiply exits once the multiplier runs out of set bits.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = ITER_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int            CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_t            state;
  logic [1:0]        op_q;
  logic              a_neg_q, b_neg_q, dz_q;
  logic [2*XLEN-1:0] acc, mcand;
  logic [XLEN-1:0]   mplier;
  logic [CW-1:0]     cnt;

  logic              in_signed, in_div, res_mul;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              a_neg, b_neg;
  logic [2*XLEN-1:0] res;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_take;

  assign in_signed = (op == OP_MULT) || (op == OP_DIV);
  assign in_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign res_mul   = (op_q == OP_MULT) || (op_q == OP_MULTU);

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .a         (a),
    .b         (b),
    .is_signed (in_signed),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .a_neg     (a_neg),
    .b_neg     (b_neg),
    .res_in    (acc),
    .is_mul    (res_mul),
    .neg_res   (a_neg_q ^ b_neg_q),
    .neg_rem   (a_neg_q),
    .res_out   (res)
  );

  // Division keeps the partial remainder in acc[63:32] and the dividend/quotient in acc[31:0].
  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, mcand[XLEN-1:0]};
  assign div_take  = ~div_diff[XLEN];

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      op_q     <= OP_MULT;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            cnt     <= '0;
            busy    <= 1'b1;
            acc     <= in_div ? {{XLEN{1'b0}}, a_mag} : '0;
            mcand   <= {{XLEN{1'b0}}, in_div ? b_mag : a_mag};
            mplier  <= b_mag;
            dz_q    <= in_div && (b == '0);
            if (!in_div)       state <= S_MUL;
            else if (b == '0)  state <= S_FIN;
            else               state <= S_DIV;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        S_MUL: begin
`ifdef MULDIV_EARLY_OUT_EN
          if (mplier == '0 && cnt != '0) state <= S_FIN;
          else
`endif
          begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) state <= S_FIN;
          end
        end
        S_DIV: begin
          acc <= {div_take ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0],
                  acc[XLEN-2:0], div_take};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= S_FIN;
        end
        S_FIN: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          div_zero <= dz_q;
          if (!dz_q) begin
            hi <= res[2*XLEN-1:XLEN];
            lo <= res[XLEN-1:0];
          end
        end
      endcase
    end
  end

endmodule
